// File: rtl/acsp_capture_engine.sv
// Probe capture engine: synchronise, decimate, keep pre-trigger history, and stream
// the pre+post trigger window to the sample FIFO with sticky overflow reporting.
module acsp_capture_engine #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int DIV_WIDTH    = 24,
    parameter int PRE_DEPTH    = 16,
    parameter int POST_WIDTH   = 16
) (
    input  logic                           system_clock,
    input  logic                           reset,
    input  logic [SAMPLE_WIDTH-1:0]        dataToSample,
    input  logic                           arm,
    input  logic                           abort,
    input  logic [DIV_WIDTH-1:0]           divider,
    input  logic [SAMPLE_WIDTH-1:0]        risePattern,
    input  logic [SAMPLE_WIDTH-1:0]        fallPattern,
    input  logic [SAMPLE_WIDTH-1:0]        levelMask,
    input  logic [SAMPLE_WIDTH-1:0]        levelValue,
    input  logic [$clog2(PRE_DEPTH):0]     preCount,
    input  logic [POST_WIDTH-1:0]          postCount,
    input  logic                           fifoFull,
    output logic [SAMPLE_WIDTH-1:0]        dataOut,
    output logic                           validOut,
    output logic [2:0]                     state,
    output logic                           triggered,
    output logic                           overflow
);
    localparam int PW = $clog2(PRE_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = ((POST_WIDTH > CW) ? POST_WIDTH : CW) + 1;

    // state | meaning: IDLE wait arm, FILL build history, ARMED search trigger, POST stream, DONE hold
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                  state_q;
    logic [SAMPLE_WIDTH-1:0] sync1_q, sync2_q, prev_q, data_q;
    logic [SAMPLE_WIDTH-1:0] rise_q, fall_q, lmask_q, lval_q;
    logic [DIV_WIDTH-1:0]    div_q, div_cnt_q;
    logic [CW-1:0]           pre_q, fill_cnt_q;
    logic [POST_WIDTH-1:0]   post_q;
    logic [TW-1:0]           emit_cnt_q;
    logic [PW-1:0]           wr_ptr_q;
    logic                    first_q, valid_q, triggered_q, overflow_q;
    logic [SAMPLE_WIDTH-1:0] hist_q [PRE_DEPTH];

    logic                    running, tick, trig_hit, emit_now, write_now, arm_ok;
    logic [SAMPLE_WIDTH-1:0] prev_eff, emit_data_d;
    logic [PW-1:0]           rd_ptr;
    logic [POST_WIDTH-1:0]   post_eff;
    logic [TW-1:0]           window;
    logic [CW-1:0]           pre_clamped_d;

    always_comb begin
        running       = (state_q == ST_FILL) || (state_q == ST_ARMED) || (state_q == ST_POST);
        tick          = running && (div_cnt_q == '0);
        prev_eff      = first_q ? sync2_q : prev_q;
        trig_hit      = (|(rise_q & ~prev_eff & sync2_q)) ||
                        (|(fall_q & prev_eff & ~sync2_q)) ||
                        ((lmask_q != '0) && (((sync2_q ^ lval_q) & lmask_q) == '0));
        emit_now      = tick && ((state_q == ST_POST) || ((state_q == ST_ARMED) && trig_hit));
        write_now     = tick && !((state_q == ST_FILL) && (pre_q == '0));
        arm_ok        = arm && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        rd_ptr        = wr_ptr_q - pre_q[PW-1:0];
        emit_data_d   = (pre_q == '0) ? sync2_q : hist_q[rd_ptr];
        post_eff      = (post_q == '0) ? POST_WIDTH'(1) : post_q;
        window        = TW'(pre_q) + TW'(post_eff);
        pre_clamped_d = (preCount > CW'(PRE_DEPTH)) ? CW'(PRE_DEPTH) : preCount;
    end

    // Read happens before overwrite, so a full-depth lookback returns the oldest entry.
    always_ff @(posedge system_clock) begin
        if (write_now) hist_q[wr_ptr_q] <= sync2_q;
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            data_q      <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            lmask_q     <= '0;
            lval_q      <= '0;
            div_q       <= '0;
            div_cnt_q   <= '0;
            pre_q       <= '0;
            fill_cnt_q  <= '0;
            post_q      <= '0;
            emit_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            first_q     <= 1'b0;
            valid_q     <= 1'b0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q <= dataToSample;
            sync2_q <= sync1_q;
            valid_q <= 1'b0;
            if (abort) begin
                state_q     <= ST_IDLE;
                triggered_q <= 1'b0;
            end else if (arm_ok) begin
                div_q       <= divider;
                rise_q      <= risePattern;
                fall_q      <= fallPattern;
                lmask_q     <= levelMask;
                lval_q      <= levelValue;
                pre_q       <= pre_clamped_d;
                post_q      <= postCount;
                div_cnt_q   <= '0;
                fill_cnt_q  <= '0;
                emit_cnt_q  <= '0;
                triggered_q <= 1'b0;
                overflow_q  <= 1'b0;
                first_q     <= 1'b1;
                state_q     <= ST_FILL;
            end else begin
                if (tick) begin
                    div_cnt_q <= div_q;
                    prev_q    <= sync2_q;
                    first_q   <= 1'b0;
                    if (write_now) wr_ptr_q <= wr_ptr_q + PW'(1);
                end else if (running) begin
                    div_cnt_q <= div_cnt_q - DIV_WIDTH'(1);
                end
                if (emit_now) begin
                    emit_cnt_q <= emit_cnt_q + TW'(1);
                    if (fifoFull) begin
                        overflow_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b1;
                        data_q  <= emit_data_d;
                    end
                end
                case (state_q)
                    ST_FILL: begin
                        if (tick) begin
                            fill_cnt_q <= fill_cnt_q + CW'(1);
                            if ((pre_q == '0) || ((fill_cnt_q + CW'(1)) == pre_q))
                                state_q <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (tick && trig_hit) begin
                            triggered_q <= 1'b1;
                            state_q     <= ((emit_cnt_q + TW'(1)) == window) ? ST_DONE : ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (tick && ((emit_cnt_q + TW'(1)) == window)) state_q <= ST_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dataOut   = data_q;
    assign validOut  = valid_q;
    assign state     = state_q;
    assign triggered = triggered_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_acsp_capture_engine.sv
// Directed bench for acsp_capture_engine: table of capture windows on a counting probe bus,
// plus hand-written abort, re-arm and reset sequences.
module tb_acsp_capture_engine;

    logic        clk;
    logic        reset;
    logic [7:0]  pins;
    logic        arm, abort, fifoFull;
    logic [23:0] divider;
    logic [7:0]  risePattern, fallPattern, levelMask, levelValue;
    logic [4:0]  preCount;
    logic [15:0] postCount;
    logic [7:0]  dataOut;
    logic        validOut, triggered, overflow;
    logic [2:0]  state;

    acsp_capture_engine dut (
        .system_clock (clk),
        .reset        (reset),
        .dataToSample (pins),
        .arm          (arm),
        .abort        (abort),
        .divider      (divider),
        .risePattern  (risePattern),
        .fallPattern  (fallPattern),
        .levelMask    (levelMask),
        .levelValue   (levelValue),
        .preCount     (preCount),
        .postCount    (postCount),
        .fifoFull     (fifoFull),
        .dataOut      (dataOut),
        .validOut     (validOut),
        .state        (state),
        .triggered    (triggered),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  start;
        logic [23:0] div;
        logic [7:0]  rise, fall, lmask, lval;
        logic [4:0]  pre;
        logic [15:0] post;
        int          full_cyc;
        int          full_len;
        int          win;
        logic [7:0]  exp_first;
        logic [7:0]  exp_step;
        int          drop_at;
        int          drop_n;
        logic        exp_ovf;
    } vec_t;

    vec_t       tbl [6];
    vec_t       v;
    logic [7:0] cap_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] ev;
    logic       pins_run;
    logic       done, got_first, trig_prev, got;
    int         n_vec, n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
        if (validOut) cap_q.push_back(dataOut);
        if (pins_run) pins = pins + 8'd1;
    endtask

    // Arranges the bus so that the first FILL tick sees sample s, then s+1, s+2, ... per clock.
    task automatic start_capture(input logic [7:0] s, input logic [23:0] dv,
                                 input logic [7:0] r, input logic [7:0] f,
                                 input logic [7:0] lm, input logic [7:0] lv,
                                 input logic [4:0] pc, input logic [15:0] po);
        pins_run    = 1'b0;
        pins        = s;
        divider     = dv;
        risePattern = r;
        fallPattern = f;
        levelMask   = lm;
        levelValue  = lv;
        preCount    = pc;
        postCount   = po;
        tick_clk();
        pins     = s + 8'd1;
        arm      = 1'b1;
        pins_run = 1'b1;
        tick_clk();
        arm = 1'b0;
        cap_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_err = 0;
        // start, div, rise, fall, lmask, lval, pre, post, full_cyc, full_len, win, first, step, drop_at, drop_n, ovf
        tbl[0] = '{8'h0D, 24'd0, 8'h01, 8'h00, 8'h00, 8'h00, 5'd4,  16'd4, -1, 0, 8,  8'h0D, 8'd1, -1, 0, 1'b0};
        tbl[1] = '{8'h90, 24'd3, 8'h00, 8'h00, 8'hF0, 8'hA0, 5'd0,  16'd3, -1, 0, 3,  8'hA0, 8'd4, -1, 0, 1'b0};
        tbl[2] = '{8'hFC, 24'd0, 8'h00, 8'h80, 8'h00, 8'h00, 5'd0,  16'd0, -1, 0, 1,  8'h00, 8'd1, -1, 0, 1'b0};
        tbl[3] = '{8'h20, 24'd0, 8'h01, 8'h00, 8'h00, 8'h00, 5'd31, 16'd4, -1, 0, 20, 8'h21, 8'd1, -1, 0, 1'b0};
        tbl[4] = '{8'h0D, 24'd0, 8'h01, 8'h00, 8'h00, 8'h00, 5'd4,  16'd4,  6, 2, 8,  8'h0D, 8'd1,  2, 2, 1'b1};
        tbl[5] = '{8'h30, 24'd1, 8'h00, 8'h00, 8'h0F, 8'h06, 5'd1,  16'd2, -1, 0, 3,  8'h34, 8'd2, -1, 0, 1'b0};

        pins = 8'h00; pins_run = 1'b1;
        arm = 1'b0; abort = 1'b0; fifoFull = 1'b0;
        divider = '0; risePattern = '0; fallPattern = '0; levelMask = '0; levelValue = '0;
        preCount = '0; postCount = '0;
        reset = 1'b1;
        repeat (3) tick_clk();
        reset = 1'b0;
        tick_clk();
        chk("reset_state",     32'(state),     32'd0);
        chk("reset_dataOut",   32'(dataOut),   32'd0);
        chk("reset_validOut",  32'(validOut),  32'd0);
        chk("reset_triggered", 32'(triggered), 32'd0);
        chk("reset_overflow",  32'(overflow),  32'd0);

        for (int k = 0; k < 6; k++) begin
            v = tbl[k];
            start_capture(v.start, v.div, v.rise, v.fall, v.lmask, v.lval, v.pre, v.post);
            chk($sformatf("v%0d_arm_state", k),     32'(state),     32'd1);
            chk($sformatf("v%0d_arm_overflow", k),  32'(overflow),  32'd0);
            chk($sformatf("v%0d_arm_triggered", k), 32'(triggered), 32'd0);
            done = 1'b0; got_first = 1'b0; trig_prev = triggered;
            for (int cyc = 0; cyc < 400 && !done; cyc++) begin
                fifoFull = (cyc >= v.full_cyc) && (cyc < v.full_cyc + v.full_len);
                tick_clk();
                if (validOut && !got_first) begin
                    got_first = 1'b1;
                    chk($sformatf("v%0d_trig_at_first", k),  32'(triggered), 32'd1);
                    chk($sformatf("v%0d_trig_before", k),    32'(trig_prev), 32'd0);
                end
                trig_prev = triggered;
                if (state == 3'd4) done = 1'b1;
            end
            fifoFull = 1'b0;
            chk($sformatf("v%0d_reached_done", k), 32'(done), 32'd1);
            repeat (4) tick_clk();
            exp_q.delete();
            for (int i = 0; i < v.win; i++) begin
                if (!((i >= v.drop_at) && (i < v.drop_at + v.drop_n))) begin
                    ev = v.exp_first + 8'(i) * v.exp_step;
                    exp_q.push_back(ev);
                end
            end
            chk($sformatf("v%0d_pulses", k), 32'(cap_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
                chk($sformatf("v%0d_data%0d", k, i), 32'(cap_q[i]), 32'(exp_q[i]));
            chk($sformatf("v%0d_state_done", k), 32'(state),    32'd4);
            chk($sformatf("v%0d_overflow", k),   32'(overflow), 32'(v.exp_ovf));
        end

        // abort with simultaneous arm in POST
        start_capture(8'h0D, 24'd0, 8'h01, 8'h00, 8'h00, 8'h00, 5'd4, 16'd40);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            tick_clk();
            if (validOut) got = 1'b1;
        end
        chk("abort_first_pulse", 32'(got), 32'd1);
        repeat (3) tick_clk();
        chk("abort_pre_state", 32'(state), 32'd3);
        abort = 1'b1; arm = 1'b1;
        tick_clk();
        abort = 1'b0; arm = 1'b0;
        chk("abort_state",     32'(state),     32'd0);
        chk("abort_validOut",  32'(validOut),  32'd0);
        chk("abort_triggered", 32'(triggered), 32'd0);
        cap_q.delete();
        repeat (10) tick_clk();
        chk("abort_quiet",      32'(cap_q.size()), 32'd0);
        chk("abort_stays_idle", 32'(state),        32'd0);

        // second arm while ARMED must not reload config
        start_capture(8'h40, 24'd0, 8'h00, 8'h00, 8'hFF, 8'h00, 5'd2, 16'd2);
        repeat (6) tick_clk();
        chk("rearm_pre_state", 32'(state), 32'd2);
        risePattern = 8'h01; levelMask = 8'h00; arm = 1'b1;
        tick_clk();
        arm = 1'b0;
        repeat (6) tick_clk();
        chk("rearm_state",     32'(state),     32'd2);
        chk("rearm_triggered", 32'(triggered), 32'd0);
        abort = 1'b1;
        tick_clk();
        abort = 1'b0;
        chk("rearm_abort_state", 32'(state), 32'd0);

        // reset in the middle of POST with overflow already set
        start_capture(8'h0D, 24'd0, 8'h01, 8'h00, 8'h00, 8'h00, 5'd4, 16'd40);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            tick_clk();
            if (validOut) got = 1'b1;
        end
        chk("rst_first_pulse", 32'(got), 32'd1);
        fifoFull = 1'b1;
        repeat (2) tick_clk();
        fifoFull = 1'b0;
        chk("rst_pre_overflow", 32'(overflow), 32'd1);
        reset = 1'b1;
        tick_clk();
        reset = 1'b0;
        chk("rst_state",     32'(state),     32'd0);
        chk("rst_dataOut",   32'(dataOut),   32'd0);
        chk("rst_validOut",  32'(validOut),  32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acsp_capture_engine.md
# acsp_capture_engine

Parametrised successor to the basic sync/sampler/trigger capture chain. The block synchronises the probe inputs and decimates them with a programmable divider. It keeps a configurable pre-trigger history and evaluates a combined edge/level trigger. It then streams exactly the pre-trigger plus post-trigger window into the downstream sample FIFO, with overflow reporting. It sits between the probe pins and the capture FIFO, under control of the host register block.

## Interface
Parameters:
- SAMPLE_WIDTH, 8, probe channel count / sample width
- DIV_WIDTH, 24, width of divider
- PRE_DEPTH, 16, pre-trigger buffer depth; power of two, at least 2
- POST_WIDTH, 16, width of postCount

Ports:
- system_clock  in  1  sole clock
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- dataToSample  in  SAMPLE_WIDTH  asynchronous probe pins
- arm  in  1  start-capture pulse
- abort  in  1  cancel-capture pulse
- divider  in  DIV_WIDTH  sample every divider+1 clocks
- risePattern / fallPattern  in  SAMPLE_WIDTH each  per-channel rising/falling edge enables
- levelMask / levelValue  in  SAMPLE_WIDTH each  level-match mask and value
- preCount  in  $clog2(PRE_DEPTH)+1  pre-trigger samples; values above PRE_DEPTH clamp to PRE_DEPTH
- postCount  in  POST_WIDTH  samples from the trigger sample onward; 0 is treated as 1
- fifoFull  in  1  downstream FIFO full
- dataOut  out  SAMPLE_WIDTH  sample to FIFO
- validOut  out  1  dataOut valid, single-cycle pulse
- state  out  3  0 IDLE, 1 FILL, 2 ARMED, 3 POST, 4 DONE
- triggered  out  1  trigger has fired
- overflow  out  1  sticky: a sample was dropped

## Operation
- Synchroniser: two flops on dataToSample produce `synced`. No edge-capture mode exists.
- Tick generator:
  - The divider counter runs only outside IDLE and DONE.
  - A tick occurs when the counter equals 0; the counter then reloads the latched divider, otherwise it decrements.
  - arm loads the counter with 0, so the first tick occurs in the first FILL cycle.
  - divider = 0 gives a tick every clock.
- Config latch: arm captures divider, patterns, masks, preCount (clamped) and postCount. These values hold until the next arm.
- History:
  - Circular buffer of PRE_DEPTH entries, written with `synced` on every tick in FILL, ARMED and POST.
  - `prev` holds the sample from the previous tick. On the first tick after arm, `prev` equals the current sample, so no edge is seen.
- Trigger (ARMED ticks only) fires when any of these holds:
  - |(risePattern & ~prev & cur)
  - |(fallPattern & prev & ~cur)
  - (levelMask != 0) and ((cur ^ levelValue) & levelMask) == 0
- With all patterns and masks at 0, the trigger never fires.
- FSM:
  - IDLE: on arm, go to FILL, and clear fill count, emitted count, triggered and overflow.
  - FILL: each tick increments the fill count. When the fill count reaches preCount, go to ARMED. With preCount = 0, FILL exits on the first tick without writing. No triggers are evaluated in FILL.
  - ARMED: on a trigger tick, go to POST; that tick is the first emission tick.
  - POST: on each tick (including the trigger tick), emit the sample captured preCount ticks earlier (the current sample when preCount = 0) and increment the emitted count. When the emitted count reaches preCount + max(postCount,1), go to DONE.
  - DONE: idle; arm restarts the sequence as from IDLE.
- Emission order: preCount pre-trigger samples oldest first, then the trigger sample, then the post samples.
- Overflow: an emission while fifoFull = 1 suppresses validOut and sets overflow. The emission still counts toward the window; capture continues.
- arm in FILL, ARMED or POST is ignored.
- abort in any state forces IDLE on the next clock and suppresses any pending validOut; abort wins over a simultaneous arm.
- triggered is set on the cycle after the trigger tick and cleared by arm, abort or reset.

## Timing
- Pin to `synced`: 2 clocks.
- Tick at cycle t: dataOut/validOut registered at t+1; state change at t+1; triggered asserts at t+1.
- validOut is high for exactly one clock per accepted emission; dataOut holds its last value otherwise.
- Reset: state IDLE, dataOut 0, validOut 0, triggered 0, overflow 0, all counters and pointers 0. Buffer contents are don't-care.
- Buffer pointer wraps modulo PRE_DEPTH. Read pointer = write pointer − preCount (mod PRE_DEPTH). A PRE_DEPTH read is a read before overwrite in the same cycle.
- Divider change while running has no effect until the next arm.

## Test plan
- Rising edge: divider=0, preCount=4, postCount=4, risePattern=0x01, counter on the pins, trigger at value 0x11 -> 8 validOut pulses carrying 0x0D..0x14, then state=4.
- Level trigger with decimation: divider=3, levelMask=0xF0, levelValue=0xA0, pins step once per clock -> ticks every 4 clocks, first emission is the matching sample, triggered high from the cycle after.
- preCount=0, postCount=0, fallPattern=0x80, bit 7 goes 1→0 -> exactly 1 validOut carrying the trigger sample.
- Clamp and wrap: PRE_DEPTH=16, preCount=31 -> 16 pre samples plus postCount samples, in order and uncorrupted across the wrap.
- fifoFull high for 2 emission ticks -> those 2 samples are absent, overflow=1, total pulses = window − 2, and overflow clears on the next arm.
- abort in POST with a simultaneous arm -> state IDLE next cycle, no further validOut. A second arm while ARMED is ignored. Reset mid-POST -> all outputs return to 0.
